// File: rtl/free_list.sv
// Circular FIFO of free physical register indices between the retirement
// register file (releases) and rename (allocations), with one-cycle flush recovery.
module free_list #(
   parameter int PRF_DEPTH = 64,
   parameter int ARF_DEPTH = 32,
   parameter int ID_WIDTH  = 2,
   parameter int PRF_IDX   = $clog2(PRF_DEPTH)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [ID_WIDTH-1:0]                    rrf_valid,
   input  logic [ID_WIDTH-1:0][PRF_IDX-1:0]       rrf_stale_idx,
   input  logic [ID_WIDTH-1:0]                    alloc_req,
   output logic                                   alloc_ready,
   output logic [ID_WIDTH-1:0][PRF_IDX-1:0]       alloc_idx,
   input  logic                                   flush,
   output logic [$clog2(PRF_DEPTH-ARF_DEPTH):0]   free_count,
   output logic                                   overflow_err
);

   localparam int FL_DEPTH = PRF_DEPTH - ARF_DEPTH;
   localparam int AW       = $clog2(FL_DEPTH);
   localparam int PW       = AW + 1;

   logic [PRF_IDX-1:0]           mem [FL_DEPTH];
   logic [PW-1:0]                rd_ptr, wr_ptr, rd_next, wr_next;
   logic [PW-1:0]                count, space, deq_cnt, enq_cnt, rd_off;
   logic [ID_WIDTH-1:0]          enq_ok;
   logic [ID_WIDTH-1:0][AW-1:0]  wr_addr;
   logic                         drop;

   // Requesting lanes are compacted onto consecutive head entries; an idle lane
   // shows the entry at its own lane offset, so the idle view is head+i.
   always_comb begin
      count       = wr_ptr - rd_ptr;
      alloc_ready = (count >= PW'(ID_WIDTH));
      deq_cnt     = '0;
      rd_off      = '0;
      alloc_idx   = '0;
      for (int unsigned i = 0; i < ID_WIDTH; i++) begin
         rd_off       = alloc_req[i] ? deq_cnt : PW'(i);
         alloc_idx[i] = mem[AW'(rd_ptr + rd_off)];
         deq_cnt      = deq_cnt + PW'(alloc_req[i]);
      end
   end

   // Room this cycle counts the slots freed by a same-cycle dequeue.
   always_comb begin
      space   = PW'(FL_DEPTH) - count + ((alloc_ready && !flush) ? deq_cnt : '0);
      enq_cnt = '0;
      enq_ok  = '0;
      wr_addr = '0;
      drop    = 1'b0;
      for (int unsigned i = 0; i < ID_WIDTH; i++) begin
         wr_addr[i] = AW'(wr_ptr + enq_cnt);
         if (rrf_valid[i]) begin
            if (enq_cnt < space) begin
               enq_ok[i] = 1'b1;
               enq_cnt   = enq_cnt + 1'b1;
            end else begin
               drop = 1'b1;
            end
         end
      end
      wr_next = wr_ptr + enq_cnt;
      rd_next = rd_ptr;
      if (flush)            rd_next = wr_next - PW'(FL_DEPTH);
      else if (alloc_ready) rd_next = rd_ptr + deq_cnt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < FL_DEPTH; i++)
            mem[i] <= PRF_IDX'(ARF_DEPTH + int'(i));
         rd_ptr       <= '0;
         wr_ptr       <= {1'b1, {AW{1'b0}}};
         free_count   <= PW'(FL_DEPTH);
         overflow_err <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < ID_WIDTH; i++)
            if (enq_ok[i]) mem[wr_addr[i]] <= rrf_stale_idx[i];
         rd_ptr     <= rd_next;
         wr_ptr     <= wr_next;
         free_count <= wr_next - rd_next;
         if (drop) overflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset, drain, refill from empty, compaction/wrap,
// flush recovery and sticky overflow with asynchronous reset.
module tb_free_list;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       rrf_valid;
   logic [1:0][5:0]  rrf_stale_idx;
   logic [1:0]       alloc_req;
   logic             alloc_ready;
   logic [1:0][5:0]  alloc_idx;
   logic             flush;
   logic [5:0]       free_count;
   logic             overflow_err;

   int checks = 0;
   int errors = 0;

   free_list #(.PRF_DEPTH(64), .ARF_DEPTH(32), .ID_WIDTH(2)) dut (
      .clk(clk), .rst(rst), .rrf_valid(rrf_valid), .rrf_stale_idx(rrf_stale_idx),
      .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
      .flush(flush), .free_count(free_count), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rrf_valid = '0; rrf_stale_idx = '0; alloc_req = '0; flush = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", alloc_ready); end
      checks++; if (alloc_idx[0] !== 6'd32) begin errors++; $display("FAIL reset_idx0 got %0d exp 32", alloc_idx[0]); end
      checks++; if (alloc_idx[1] !== 6'd33) begin errors++; $display("FAIL reset_idx1 got %0d exp 33", alloc_idx[1]); end
      checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL reset_count got %0d exp 32", free_count); end
      checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", overflow_err); end
   endtask

   task automatic test_drain();
      do_reset();
      for (int k = 0; k < 16; k++) begin
         alloc_req = 2'b11;
         #1;
         checks++; if (alloc_idx[0] !== 6'(32 + 2*k) || alloc_idx[1] !== 6'(33 + 2*k) || alloc_ready !== 1'b1) begin
            errors++; $display("FAIL drain_%0d got %0d,%0d rdy %0b exp %0d,%0d rdy 1",
                               k, alloc_idx[0], alloc_idx[1], alloc_ready, 32 + 2*k, 33 + 2*k);
         end
         step();
      end
      alloc_req = 2'b00;
      #1;
      checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL drain_empty_ready got %0b exp 0", alloc_ready); end
      checks++; if (free_count !== 6'd0) begin errors++; $display("FAIL drain_empty_count got %0d exp 0", free_count); end
      alloc_req = 2'b11;
      step();
      alloc_req = 2'b00;
      step();
      checks++; if (free_count !== 6'd0 || alloc_ready !== 1'b0) begin
         errors++; $display("FAIL drain_ignored_req got cnt %0d rdy %0b exp cnt 0 rdy 0", free_count, alloc_ready);
      end
   endtask

   // Continues from the empty state left by test_drain.
   task automatic test_refill();
      rrf_valid = 2'b10; rrf_stale_idx[1] = 6'd5; rrf_stale_idx[0] = 6'd9;
      #1;
      checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL refill_bypass got %0b exp 0", alloc_ready); end
      step();
      idle_inputs();
      #1;
      checks++; if (free_count !== 6'd1 || alloc_ready !== 1'b0) begin
         errors++; $display("FAIL refill_one got cnt %0d rdy %0b exp cnt 1 rdy 0", free_count, alloc_ready);
      end
      rrf_valid = 2'b01; rrf_stale_idx[0] = 6'd7;
      step();
      idle_inputs();
      #1;
      checks++; if (alloc_idx[0] !== 6'd5 || alloc_idx[1] !== 6'd7) begin
         errors++; $display("FAIL refill_pair got %0d,%0d exp 5,7", alloc_idx[0], alloc_idx[1]);
      end
      checks++; if (free_count !== 6'd2 || alloc_ready !== 1'b1) begin
         errors++; $display("FAIL refill_count got cnt %0d rdy %0b exp cnt 2 rdy 1", free_count, alloc_ready);
      end
   endtask

   task automatic test_compaction_wrap();
      do_reset();
      alloc_req = 2'b10;
      #1;
      checks++; if (alloc_idx[1] !== 6'd32) begin errors++; $display("FAIL compact_lane1 got %0d exp 32", alloc_idx[1]); end
      step();
      alloc_req = 2'b00;
      #1;
      checks++; if (alloc_idx[0] !== 6'd33 || free_count !== 6'd31) begin
         errors++; $display("FAIL compact_next got idx %0d cnt %0d exp idx 33 cnt 31", alloc_idx[0], free_count);
      end
      for (int k = 0; k < 15; k++) begin
         alloc_req = 2'b11;
         step();
      end
      alloc_req = 2'b00;
      #1;
      // head at slot 31, lane 1 view wraps to slot 0
      checks++; if (alloc_idx[0] !== 6'd63 || alloc_idx[1] !== 6'd32 || free_count !== 6'd1 || alloc_ready !== 1'b0) begin
         errors++; $display("FAIL wrap_read got %0d,%0d cnt %0d rdy %0b exp 63,32 cnt 1 rdy 0",
                            alloc_idx[0], alloc_idx[1], free_count, alloc_ready);
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         alloc_req = 2'b11;
         step();
      end
      alloc_req = 2'b00;
      rrf_valid = 2'b11; rrf_stale_idx[0] = 6'd1; rrf_stale_idx[1] = 6'd2;
      step();
      rrf_valid = 2'b11; rrf_stale_idx[0] = 6'd3; rrf_stale_idx[1] = 6'd4;
      alloc_req = 2'b11;
      flush = 1'b1;
      step();
      idle_inputs();
      #1;
      checks++; if (free_count !== 6'd32 || alloc_ready !== 1'b1) begin
         errors++; $display("FAIL flush_state got cnt %0d rdy %0b exp cnt 32 rdy 1", free_count, alloc_ready);
      end
      checks++; if (alloc_idx[0] !== 6'd36 || alloc_idx[1] !== 6'd37) begin
         errors++; $display("FAIL flush_head got %0d,%0d exp 36,37", alloc_idx[0], alloc_idx[1]);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      rrf_valid = 2'b11; rrf_stale_idx[0] = 6'd1; rrf_stale_idx[1] = 6'd2;
      step();
      idle_inputs();
      #1;
      checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", overflow_err); end
      checks++; if (free_count !== 6'd32 || alloc_idx[0] !== 6'd32 || alloc_idx[1] !== 6'd33) begin
         errors++; $display("FAIL ovf_contents got cnt %0d idx %0d,%0d exp cnt 32 idx 32,33",
                            free_count, alloc_idx[0], alloc_idx[1]);
      end
      alloc_req = 2'b11;
      step();
      step();
      checks++; if (overflow_err !== 1'b1 || free_count !== 6'd28) begin
         errors++; $display("FAIL ovf_sticky got ovf %0b cnt %0d exp ovf 1 cnt 28", overflow_err, free_count);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (overflow_err !== 1'b0 || free_count !== 6'd32 || alloc_idx[0] !== 6'd32 || alloc_idx[1] !== 6'd33) begin
         errors++; $display("FAIL async_reset got ovf %0b cnt %0d idx %0d,%0d exp ovf 0 cnt 32 idx 32,33",
                            overflow_err, free_count, alloc_idx[0], alloc_idx[1]);
      end
      step();
      rst = 1'b1;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      #2;
      test_reset();
      test_drain();
      test_refill();
      test_compaction_wrap();
      test_flush();
      test_overflow();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
